// File: rtl/pipe_fifo_buffer.sv
// DEPTH-deep circular word buffer between an okPipeIn (write) and an okPipeOut
// (read) endpoint. Supports a FIFO read mode and a non-destructive replay mode.
// It also keeps saturating overflow/underflow counters and supports a soft flush.
module pipe_fifo_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                         okClk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         mode,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             overflow_cnt,
    output logic [CNT_W-1:0]             underflow_cnt,
    output logic [7:0]                   last_word
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Storage: written synchronously, read through the registered rd_data port.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg,     rd_ptr_next;
    logic [ADDR_W-1:0] replay_ptr_reg, replay_ptr_next;
    logic [ADDR_W:0]   replay_idx_reg, replay_idx_next;
    logic [ADDR_W:0]   count_reg,      count_next;
    logic [DATA_W-1:0] rd_data_reg,    rd_data_next;
    logic [CNT_W-1:0]  ovf_reg,        ovf_next;
    logic [CNT_W-1:0]  unf_reg,        unf_next;
    logic [7:0]        last_word_reg,  last_word_next;

    logic              is_full;
    logic              is_empty;
    logic              pop;
    logic              wr_accept;
    logic [ADDR_W-1:0] rd_addr;

    // Next-state computation for pointers, occupancy, read data and counters.
    always_comb begin
        is_full         = (count_reg == DEPTH_C);
        is_empty        = (count_reg == '0);
        pop             = ~mode & rd_en & ~is_empty;
        wr_accept       = wr_en & (~is_full | pop);
        rd_addr         = mode ? replay_ptr_reg : rd_ptr_reg;

        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        replay_ptr_next = replay_ptr_reg;
        replay_idx_next = replay_idx_reg;
        count_next      = count_reg;
        rd_data_next    = rd_data_reg;
        ovf_next        = ovf_reg;
        unf_next        = unf_reg;
        last_word_next  = last_word_reg;

        if (wr_accept) begin
            wr_ptr_next    = wr_ptr_reg + 1'b1;
            last_word_next = wr_data[7:0];
        end else if (wr_en && ovf_reg != '1) begin
            ovf_next = ovf_reg + 1'b1;
        end

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        if (rd_en) begin
            if (is_empty) begin
                // Reads while empty return zero regardless of mode.
                rd_data_next = '0;
                if (unf_reg != '1) begin
                    unf_next = unf_reg + 1'b1;
                end
            end else begin
                rd_data_next = mem[rd_addr];
            end
        end

        if (!mode) begin
            // Keep replay aligned with the oldest word so replay always starts there.
            replay_ptr_next = rd_ptr_next;
            replay_idx_next = '0;
        end else if (rd_en && !is_empty) begin
            if (replay_idx_reg == count_reg - 1'b1) begin
                replay_ptr_next = rd_ptr_reg;
                replay_idx_next = '0;
            end else begin
                replay_ptr_next = replay_ptr_reg + 1'b1;
                replay_idx_next = replay_idx_reg + 1'b1;
            end
        end

        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // State register: reset clears everything, clr empties but keeps counters and outputs.
    always_ff @(posedge okClk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            replay_ptr_reg <= '0;
            replay_idx_reg <= '0;
            count_reg      <= '0;
            rd_data_reg    <= '0;
            ovf_reg        <= '0;
            unf_reg        <= '0;
            last_word_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            replay_ptr_reg <= '0;
            replay_idx_reg <= '0;
            count_reg      <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            replay_ptr_reg <= replay_ptr_next;
            replay_idx_reg <= replay_idx_next;
            count_reg      <= count_next;
            rd_data_reg    <= rd_data_next;
            ovf_reg        <= ovf_next;
            unf_reg        <= unf_next;
            last_word_reg  <= last_word_next;
        end
    end

    // Memory write port; a new word is readable from the following cycle.
    always_ff @(posedge okClk) begin
        if (!rst && !clr && wr_accept) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data       = rd_data_reg;
    assign count         = count_reg;
    assign full          = is_full;
    assign empty         = is_empty;
    assign overflow_cnt  = ovf_reg;
    assign underflow_cnt = unf_reg;
    assign last_word     = last_word_reg;

endmodule

// File: tb/tb_pipe_fifo_buffer.sv
// Scoreboard bench for pipe_fifo_buffer: stimulus pushes expected read words,
// a monitor pops and compares one cycle after each read strobe.
module tb_pipe_fifo_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              okClk = 1'b0;
    logic              rst   = 1'b1;
    logic              clr   = 1'b0;
    logic              mode  = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  overflow_cnt;
    logic [CNT_W-1:0]  underflow_cnt;
    logic [7:0]        last_word;

    int tests_run = 0;
    int tests_failed = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic rd_seen = 1'b0;

    pipe_fifo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .okClk(okClk), .rst(rst), .clr(clr), .mode(mode),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .count(count), .full(full), .empty(empty),
        .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt),
        .last_word(last_word)
    );

    always #5 okClk = ~okClk;

    // Remember which edges carried a live read so the monitor knows when rd_data is due.
    always @(posedge okClk) rd_seen <= rd_en && !rst && !clr;

    // Monitor: pops the scoreboard and compares rd_data between clock edges.
    always @(negedge okClk) begin
        if (rd_seen) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rd_data_unexpected: got %h, required no read response", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    tests_failed++;
                    $display("FAIL rd_data: got %h, required %h", rd_data, e);
                end else begin
                    $display("[TB] read ok %h", rd_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("[TB] %s ok %h", name, got);
        end
    endtask

    // One clock cycle with the given strobes; returns 1 ns after the active edge.
    task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge okClk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic rd(input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        step(1'b0, '0, 1'b1);
    endtask

    logic [DATA_W-1:0] wa, wb, wc;

    initial begin
        wa = 32'hA5A5_0001;
        wb = 32'hB6B6_0002;
        wc = 32'hC7C7_0003;

        // Reset state
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_ovf", 32'(overflow_cnt), 32'd0);
        check("reset_unf", 32'(underflow_cnt), 32'd0);
        check("reset_last_word", 32'(last_word), 32'd0);

        // Fill 16 then drain 16 in order
        for (int i = 0; i < 16; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
        check("fill_count", 32'(count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_last_word", 32'(last_word), 32'h0F);
        for (int i = 0; i < 16; i++) rd(32'h1000_0000 + 32'(i));
        step(1'b0, '0, 1'b0);
        check("drain_count", 32'(count), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        // Overflow: 17th write dropped
        for (int i = 0; i < 17; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
        check("ovf_cnt", 32'(overflow_cnt), 32'd1);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_last_word", 32'(last_word), 32'h0F);
        for (int i = 0; i < 16; i++) rd(32'h2000_0000 + 32'(i));
        step(1'b0, '0, 1'b0);
        check("ovf_drain_empty", 32'(empty), 32'd1);

        // Replay mode
        step(1'b1, wa, 1'b0);
        step(1'b1, wb, 1'b0);
        step(1'b1, wc, 1'b0);
        mode = 1'b1;
        rd(wa); rd(wb); rd(wc); rd(wa); rd(wb); rd(wc); rd(wa);
        check("replay_count", 32'(count), 32'd3);
        mode = 1'b0;
        rd(wa);
        check("replay_exit_count", 32'(count), 32'd2);
        rd(wb);
        rd(wc);
        step(1'b0, '0, 1'b0);

        // Simultaneous write and read while empty
        exp_q.push_back(32'd0);
        step(1'b1, 32'hD00D_0044, 1'b1);
        check("empty_wr_rd_unf", 32'(underflow_cnt), 32'd1);
        check("empty_wr_rd_count", 32'(count), 32'd1);
        rd(32'hD00D_0044);
        step(1'b0, '0, 1'b0);
        check("empty_wr_rd_drained", 32'(count), 32'd0);

        // Full with concurrent write and pop, across pointer wrap
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(32'h3000_0000 + 32'(k));
            step(1'b1, 32'h3000_0010 + 32'(k), 1'b1);
            check("full_wr_rd_count", 32'(count), 32'd16);
        end
        check("full_wr_rd_ovf", 32'(overflow_cnt), 32'd1);
        for (int i = 5; i < 21; i++) rd(32'h3000_0000 + 32'(i));
        step(1'b0, '0, 1'b0);
        check("wrap_drain_empty", 32'(empty), 32'd1);

        // Soft flush
        for (int i = 0; i < 5; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
        clr = 1'b1;
        step(1'b0, '0, 1'b0);
        clr = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        rd(32'hDEAD_BEEF);
        step(1'b0, '0, 1'b0);
        check("clr_ovf_kept", 32'(overflow_cnt), 32'd1);
        check("clr_unf_kept", 32'(underflow_cnt), 32'd1);
        check("clr_last_word", 32'(last_word), 32'hEF);
        check("clr_empty", 32'(empty), 32'd1);

        // Reset returns all outputs to zero
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("rst2_rd_data", rd_data, 32'd0);
        check("rst2_ovf", 32'(overflow_cnt), 32'd0);
        check("rst2_unf", 32'(underflow_cnt), 32'd0);
        check("rst2_last_word", 32'(last_word), 32'd0);
        check("rst2_count", 32'(count), 32'd0);

        step(1'b0, '0, 1'b0);
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
